ccp_tag_mem_init: RTL and testbench

Writer side of the CCP tag-memory contract. After reset, and on flush request, it walks every bank/index and writes invalid entries into the tag RAM. Once init completes it accepts single-way seed writes of `{valid, tag, state}` through a valid/ready port. It sits between the CCP control pipe and the tag-RAM write port. Every tag row it produces is guaranteed to satisfy the row format the formal reset abstraction checks: 27-bit entries, `{1'b1, tag, state}` for valid ways, zero for invalid ways.

---
 rtl/ccp_tag_mem_init.sv | 167 ++++++++++++++++
 tb/tb_ccp_tag_mem_init.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccp_tag_mem_init.sv
// Tag-RAM writer: after reset or flush it invalidates every bank/index row, then it accepts single-way seed writes.
// Optional macro CCP_TAG_INIT_PARITY_EN adds an even-parity bit as the MSB of each entry.
module ccp_tag_mem_init #(
  parameter int N_WAYS              = 4,
  parameter int ADDRESS_W           = 40,
  parameter int CACHE_LINE_OFFSET_W = 6,
  parameter int N_TAG_BANKS         = 2,
  parameter int N_SETS              = 1024,
  parameter int STATE_W             = 2,
  localparam int BNK_W          = $clog2(N_TAG_BANKS),
  localparam int SET_PER_BANK   = N_SETS / N_TAG_BANKS,
  localparam int SET_PER_BANK_W = $clog2(SET_PER_BANK),
  localparam int WAY_W          = $clog2(N_WAYS),
  localparam int TAG_W          = ADDRESS_W - BNK_W - CACHE_LINE_OFFSET_W - SET_PER_BANK_W,
`ifdef CCP_TAG_INIT_PARITY_EN
  localparam int ENTRY_W        = 2 + TAG_W + STATE_W,
`else
  localparam int ENTRY_W        = 1 + TAG_W + STATE_W,
`endif
  localparam int ROW_W          = N_WAYS * ENTRY_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_req,
  input  logic                      seed_valid,
  output logic                      seed_ready,
  input  logic [BNK_W-1:0]          seed_bank,
  input  logic [SET_PER_BANK_W-1:0] seed_index,
  input  logic [WAY_W-1:0]          seed_way,
  input  logic [TAG_W-1:0]          seed_tag,
  input  logic [STATE_W-1:0]        seed_state,
  output logic                      mem_wr_valid,
  input  logic                      mem_wr_ready,
  output logic [BNK_W-1:0]          mem_wr_bank,
  output logic [SET_PER_BANK_W-1:0] mem_wr_index,
  output logic [N_WAYS-1:0]         mem_wr_way_mask,
  output logic [ROW_W-1:0]          mem_wr_data,
  output logic                      init_done,
  output logic                      busy
);

  localparam int CNT_W = BNK_W + SET_PER_BANK_W;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_SETS - 1);

  typedef enum logic [1:0] {IDLE, INIT, READY, SEED} state_t;

  state_t                    r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic                      r_wr_valid, w_wr_valid_next;
  logic [BNK_W-1:0]          r_bank, w_bank_next;
  logic [SET_PER_BANK_W-1:0] r_index, w_index_next;
  logic [N_WAYS-1:0]         r_mask, w_mask_next;
  logic [ROW_W-1:0]          r_data, w_data_next;
  logic                      r_init_done, w_init_done_next;
  logic                      r_busy, w_busy_next;

  logic [ENTRY_W-1:0]        w_entry;
  logic [ROW_W-1:0]          w_row;

  // A zero state means invalidate, and invalid ways must read back as all zeros.
  always_comb begin
    w_entry = '0;
    if (seed_state != '0) begin
`ifdef CCP_TAG_INIT_PARITY_EN
      w_entry = {^{1'b1, seed_tag, seed_state}, 1'b1, seed_tag, seed_state};
`else
      w_entry = {1'b1, seed_tag, seed_state};
`endif
    end
  end

  // The same entry goes into every way slot; the way mask picks the one that is written.
  generate
    for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_row
      assign w_row[gi*ENTRY_W +: ENTRY_W] = w_entry;
    end
  endgenerate

  assign seed_ready = (r_state == READY) && !flush_req;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_wr_valid_next = r_wr_valid;
    w_bank_next     = r_bank;
    w_index_next    = r_index;
    w_mask_next     = r_mask;
    w_data_next     = r_data;
    case (r_state)
      IDLE: w_state_next = INIT;
      INIT: begin
        if (!r_wr_valid) begin
          w_wr_valid_next             = 1'b1;
          w_mask_next                 = '1;
          w_data_next                 = '0;
          {w_bank_next, w_index_next} = r_cnt;
        end else if (mem_wr_ready) begin
          if (r_cnt == LAST_ROW) begin
            w_state_next    = READY;
            w_cnt_next      = '0;
            w_wr_valid_next = 1'b0;
            w_mask_next     = '0;
          end else begin
            w_cnt_next                  = r_cnt + CNT_W'(1);
            {w_bank_next, w_index_next} = r_cnt + CNT_W'(1);
          end
        end
      end
      READY: begin
        if (flush_req) begin
          w_state_next = INIT;
          w_cnt_next   = '0;
        end else if (seed_valid) begin
          w_state_next    = SEED;
          w_wr_valid_next = 1'b1;
          w_mask_next     = N_WAYS'(1) << seed_way;
          w_data_next     = w_row;
          w_bank_next     = seed_bank;
          w_index_next    = seed_index;
        end
      end
      SEED: begin
        if (mem_wr_ready) begin
          w_state_next    = READY;
          w_wr_valid_next = 1'b0;
          w_mask_next     = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_init_done_next = (w_state_next == READY) || (w_state_next == SEED);
    w_busy_next      = !w_init_done_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr_valid  <= 1'b0;
      r_bank      <= '0;
      r_index     <= '0;
      r_mask      <= '0;
      r_data      <= '0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_wr_valid  <= w_wr_valid_next;
      r_bank      <= w_bank_next;
      r_index     <= w_index_next;
      r_mask      <= w_mask_next;
      r_data      <= w_data_next;
      r_init_done <= w_init_done_next;
      r_busy      <= w_busy_next;
    end
  end

  assign mem_wr_valid    = r_wr_valid;
  assign mem_wr_bank     = r_bank;
  assign mem_wr_index    = r_index;
  assign mem_wr_way_mask = r_mask;
  assign mem_wr_data     = r_data;
  assign init_done       = r_init_done;
  assign busy            = r_busy;

endmodule

// File: tb/tb_ccp_tag_mem_init.sv
// Directed bench for ccp_tag_mem_init: init sweeps, seed vector table, flush and reset corner cases.
module tb_ccp_tag_mem_init;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush_req;
  logic         seed_valid;
  logic         seed_ready;
  logic [0:0]   seed_bank;
  logic [8:0]   seed_index;
  logic [1:0]   seed_way;
  logic [23:0]  seed_tag;
  logic [1:0]   seed_state;
  logic         mem_wr_valid;
  logic         mem_wr_ready;
  logic [0:0]   mem_wr_bank;
  logic [8:0]   mem_wr_index;
  logic [3:0]   mem_wr_way_mask;
  logic [107:0] mem_wr_data;
  logic         init_done;
  logic         busy;

  always #5 clk = ~clk;

  ccp_tag_mem_init dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush_req       (flush_req),
    .seed_valid      (seed_valid),
    .seed_ready      (seed_ready),
    .seed_bank       (seed_bank),
    .seed_index      (seed_index),
    .seed_way        (seed_way),
    .seed_tag        (seed_tag),
    .seed_state      (seed_state),
    .mem_wr_valid    (mem_wr_valid),
    .mem_wr_ready    (mem_wr_ready),
    .mem_wr_bank     (mem_wr_bank),
    .mem_wr_index    (mem_wr_index),
    .mem_wr_way_mask (mem_wr_way_mask),
    .mem_wr_data     (mem_wr_data),
    .init_done       (init_done),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [0:0]  bank;
    logic [8:0]  index;
    logic [1:0]  way;
    logic [23:0] tag;
    logic [1:0]  state;
    int          stall;
    logic [3:0]  exp_mask;
    logic [26:0] exp_entry;
  } seed_vec_t;

  seed_vec_t vecs[5];

  task automatic check_reset_vals(input string name);
    check({name, "_valid"}, mem_wr_valid, 0);
    check({name, "_mask"}, mem_wr_way_mask, 0);
    check({name, "_data"}, mem_wr_data, 0);
    check({name, "_bankidx"}, {mem_wr_bank, mem_wr_index}, 0);
    check({name, "_init_done"}, init_done, 0);
    check({name, "_busy"}, busy, 1);
  endtask

  // Holds reset for two edges, releases it just after an edge, then steps through edge 0 (IDLE).
  task automatic do_reset(input string name);
    reset_n = 1'b0;
    flush_req = 1'b0; seed_valid = 1'b0; mem_wr_ready = 1'b0;
    seed_bank = '0; seed_index = '0; seed_way = '0; seed_tag = '0; seed_state = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(name);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check({name, "_edge0_valid"}, mem_wr_valid, 0);
    check({name, "_edge0_busy"}, busy, 1);
    $display("reset %s done", name);
  endtask

  // Entered just after the edge that moves the FSM into INIT; runs until init_done.
  task automatic run_init(input bit toggle, input bit disturb, input string name);
    int exp_row = 0, n = 0, stalls = 0;
    int bad_idx = 0, bad_pl = 0, bad_stab = 0, bad_misc = 0;
    bit prev_stall = 0;
    logic [121:0] saved = '0;
    while (!init_done && n < 4000) begin
      mem_wr_ready = toggle ? n[0] : 1'b1;
      flush_req    = disturb;
      seed_valid   = disturb;
      #1;
      if (seed_ready !== 1'b0 || busy !== 1'b1) bad_misc++;
      if (prev_stall && {mem_wr_bank, mem_wr_index, mem_wr_way_mask, mem_wr_data} !== saved) bad_stab++;
      if (mem_wr_valid) begin
        if (mem_wr_ready) begin
          if (exp_row > 1023 || {mem_wr_bank, mem_wr_index} !== 10'(exp_row)) bad_idx++;
          if (mem_wr_way_mask !== 4'hF || mem_wr_data !== '0) bad_pl++;
          exp_row++;
        end else begin
          stalls++;
        end
        prev_stall = !mem_wr_ready;
        saved = {mem_wr_bank, mem_wr_index, mem_wr_way_mask, mem_wr_data};
      end else begin
        prev_stall = 0;
      end
      @(posedge clk); #1;
      n++;
    end
    flush_req = 1'b0; seed_valid = 1'b0; mem_wr_ready = 1'b1;
    $display("init %s: %0d writes, %0d stalls, init_done after %0d cycles", name, exp_row, stalls, n);
    check({name, "_writes"}, exp_row, 1024);
    check({name, "_index_seq"}, bad_idx, 0);
    check({name, "_payload"}, bad_pl, 0);
    check({name, "_stall_stable"}, bad_stab, 0);
    check({name, "_busy_seedrdy"}, bad_misc, 0);
    check({name, "_cycles"}, n, 1025 + stalls);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_valid_after"}, mem_wr_valid, 0);
  endtask

  task automatic apply_seed(input seed_vec_t v, input int k);
    logic [107:0] exp_row;
    string nm;
    nm = $sformatf("seed%0d", k);
    exp_row = {4{v.exp_entry}};
    seed_bank = v.bank; seed_index = v.index; seed_way = v.way;
    seed_tag = v.tag; seed_state = v.state;
    seed_valid = 1'b1;
    mem_wr_ready = (v.stall == 0);
    #1;
    check({nm, "_ready"}, seed_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs and raise flush: the write must use latched fields and SEED ignores flush.
    seed_valid = 1'b0; seed_tag = ~v.tag; seed_way = v.way + 2'd1; seed_state = ~v.state;
    flush_req = 1'b1;
    #1;
    check({nm, "_valid"}, mem_wr_valid, 1);
    check({nm, "_mask"}, mem_wr_way_mask, v.exp_mask);
    check({nm, "_bankidx"}, {mem_wr_bank, mem_wr_index}, {v.bank, v.index});
    check({nm, "_data"}, mem_wr_data, exp_row);
    check({nm, "_busy_seedrdy"}, {seed_ready, init_done, busy}, 3'b010);
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk); #1;
      if (s == v.stall - 1) mem_wr_ready = 1'b1;
      check({nm, "_stall_hold"}, {mem_wr_valid, mem_wr_way_mask, mem_wr_data}, {1'b1, v.exp_mask, exp_row});
    end
    @(posedge clk); #1;
    flush_req = 1'b0;
    #1;
    check({nm, "_done"}, {mem_wr_valid, init_done, busy, seed_ready}, 4'b0101);
    $display("seed %0d: bank=%0d index=%0d way=%0d mask=%h", k, v.bank, v.index, v.way, mem_wr_way_mask);
  endtask

  initial begin
    vecs[0] = '{1'b1, 9'd5,   2'd2, 24'hABCDEF, 2'b01, 0, 4'b0100, 27'h6AF37BD};
    vecs[1] = '{1'b0, 9'd0,   2'd0, 24'hFFFFFF, 2'b00, 0, 4'b0001, 27'h0000000};
    vecs[2] = '{1'b1, 9'd511, 2'd3, 24'h000001, 2'b11, 0, 4'b1000, 27'h4000007};
    vecs[3] = '{1'b0, 9'd256, 2'd1, 24'h123456, 2'b10, 0, 4'b0010, 27'h448D15A};
    vecs[4] = '{1'b1, 9'd100, 2'd0, 24'h800000, 2'b10, 2, 4'b0001, 27'h6000002};

    do_reset("por");
    run_init(1'b0, 1'b0, "init");

    for (int k = 0; k < 5; k++) apply_seed(vecs[k], k);

    // Flush and seed in the same READY cycle: flush wins, no seed write.
    seed_bank = 1'b1; seed_index = 9'd7; seed_way = 2'd1; seed_tag = 24'h55AA55; seed_state = 2'b01;
    seed_valid = 1'b1; flush_req = 1'b1;
    #1;
    check("flush_seed_ready", seed_ready, 0);
    @(posedge clk); #1;
    seed_valid = 1'b0; flush_req = 1'b0;
    check("flush_state", {mem_wr_valid, init_done, busy}, 3'b001);
    run_init(1'b0, 1'b0, "flush");

    // Plain flush, then a stalling init with flush/seed requests held high throughout.
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    check("flush2_init_done", init_done, 0);
    run_init(1'b1, 1'b1, "stall");

    // Reset pulse in the middle of INIT at row 300.
    begin
      int guard = 0;
      bit reached = 0;
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      mem_wr_ready = 1'b1;
      while (!reached && guard < 1000) begin
        if (mem_wr_valid && {mem_wr_bank, mem_wr_index} == 10'd300) reached = 1;
        else begin @(posedge clk); #1; guard++; end
      end
      check("mid_reached_300", reached, 1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
    end
    do_reset("rerst");
    run_init(1'b0, 1'b0, "reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
